// File: rtl/qm_muldiv.sv
// ---------------------------------------------------------------------------
// qm_muldiv -- iterative 32x32 multiply / divide unit with HI/LO registers.
//
// One radix-2 step per cycle: shift-add for multiply, restoring division for
// divide, always on unsigned magnitudes. Signs are restored in a single
// FINISH cycle, which is the only time HI/LO are written by an operation.
//
// Optional feature macro: QM_MULDIV_DIV_EN
//   defined   : DIV/DIVU run through the restoring divider.
//   undefined : no divider datapath; a divide start pulses o_Done the next
//               cycle without touching HI/LO or raising o_Busy.
//
// Handshake: i_Start is taken only when the FSM is IDLE, and then takes
// priority over MTHI/MTLO in that cycle. While o_Busy=1, i_Start and the
// write strobes are ignored, and co_Stall tells the pipeline to hold any
// instruction that wants the unit (start, HI/LO read or HI/LO write).
//
// Ports:
//   i_Clock, i_Reset      clock (rising edge), async active-high reset
//   i_Start, i_Op[1:0]    request; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_A, i_B [31:0]       operands, latched on an accepted start
//   i_Access              pipeline reads HI/LO this cycle
//   i_HIWrite, i_LOWrite  MTHI / MTLO strobes, data on i_WData[31:0]
//   o_HI, o_LO [31:0]     architectural HI / LO
//   o_Busy                operation in progress (RUN or FINISH)
//   o_Done                one-cycle completion pulse
//   co_Stall              combinational stall request
// ---------------------------------------------------------------------------
module qm_muldiv (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Start,
    input  logic [1:0]  i_Op,
    input  logic [31:0] i_A,
    input  logic [31:0] i_B,
    input  logic        i_Access,
    input  logic        i_HIWrite,
    input  logic        i_LOWrite,
    input  logic [31:0] i_WData,
    output logic [31:0] o_HI,
    output logic [31:0] o_LO,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        co_Stall
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // r_State is the single place to observe FSM progress.
    state_t      r_State;
    state_t      w_NextState;

    logic [31:0] r_HI;
    logic [31:0] r_LO;
    logic        r_Done;
    logic [4:0]  r_Count;
    // Working registers: r_WHi is the product high half / partial remainder,
    // r_WLo the multiplier / dividend being shifted out (quotient shifted in).
    logic [31:0] r_WHi;
    logic [31:0] r_WLo;
    logic [31:0] r_M;
    logic        r_NegQ;

    logic        w_Accept;
    logic        w_Launch;
    logic        w_DivReject;
    logic        w_IsDiv;
    logic        w_Signed;
    logic        w_SignA;
    logic        w_SignB;
    logic [31:0] w_MagA;
    logic [31:0] w_MagB;

    logic [32:0] w_MulSum;
    logic [63:0] w_Prod;
    logic [63:0] w_ProdFix;
    logic [31:0] w_StepHi;
    logic [31:0] w_StepLo;
    logic [31:0] w_FinHi;
    logic [31:0] w_FinLo;

    assign w_IsDiv  = i_Op[1];
    assign w_Signed = ~i_Op[0];
    assign w_SignA  = w_Signed & i_A[31];
    assign w_SignB  = w_Signed & i_B[31];
    assign w_MagA   = w_SignA ? (32'd0 - i_A) : i_A;
    assign w_MagB   = w_SignB ? (32'd0 - i_B) : i_B;
    assign w_Accept = (r_State == IDLE) & i_Start;

`ifdef QM_MULDIV_DIV_EN
    logic        r_OpDiv;
    logic        r_NegR;
    logic        r_DivZero;
    logic [31:0] r_A;
    logic [32:0] w_DivShift;
    logic        w_DivOk;
    logic [31:0] w_DivDiff;

    assign w_Launch    = w_Accept;
    assign w_DivReject = 1'b0;

    // Divide-only operation attributes, captured alongside the operands.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_OpDiv   <= 1'b0;
            r_NegR    <= 1'b0;
            r_DivZero <= 1'b0;
            r_A       <= '0;
        end else if (w_Launch) begin
            r_OpDiv   <= w_IsDiv;
            r_NegR    <= w_SignA;
            r_DivZero <= (i_B == 32'd0);
            r_A       <= i_A;
        end
    end

    // Restoring step: remainder stays below the divisor, so when the trial
    // subtraction succeeds the true difference fits in 32 bits.
    assign w_DivShift = {r_WHi, r_WLo[31]};
    assign w_DivOk    = (w_DivShift >= {1'b0, r_M});
    assign w_DivDiff  = w_DivShift[31:0] - r_M;
`else
    // Without a divider, divide requests complete immediately as no-ops.
    assign w_Launch    = w_Accept & ~w_IsDiv;
    assign w_DivReject = w_Accept & w_IsDiv;
`endif

    // Datapath step and final sign correction.
    always_comb begin
        w_MulSum  = {1'b0, r_WHi} + (r_WLo[0] ? {1'b0, r_M} : 33'd0);
        w_StepHi  = w_MulSum[32:1];
        w_StepLo  = {w_MulSum[0], r_WLo[31:1]};
        w_Prod    = {r_WHi, r_WLo};
        w_ProdFix = r_NegQ ? (64'd0 - w_Prod) : w_Prod;
        w_FinHi   = w_ProdFix[63:32];
        w_FinLo   = w_ProdFix[31:0];
`ifdef QM_MULDIV_DIV_EN
        if (r_OpDiv) begin
            w_StepHi = w_DivOk ? w_DivDiff : w_DivShift[31:0];
            w_StepLo = {r_WLo[30:0], w_DivOk};
            if (r_DivZero) begin
                w_FinHi = r_A;
                w_FinLo = 32'hFFFF_FFFF;
            end else begin
                // Remainder follows the dividend's sign.
                w_FinHi = r_NegR ? (32'd0 - r_WHi) : r_WHi;
                w_FinLo = r_NegQ ? (32'd0 - r_WLo) : r_WLo;
            end
        end
`endif
    end

    // FSM: state register.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State <= IDLE;
        end else begin
            r_State <= w_NextState;
        end
    end

    // FSM: next state.
    always_comb begin
        w_NextState = r_State;
        case (r_State)
            IDLE:    if (w_Launch) w_NextState = RUN;
            RUN:     if (r_Count == 5'd0) w_NextState = FINISH;
            FINISH:  w_NextState = IDLE;
            default: w_NextState = IDLE;
        endcase
    end

    // Datapath and architectural registers.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_HI    <= '0;
            r_LO    <= '0;
            r_Done  <= 1'b0;
            r_Count <= '0;
            r_WHi   <= '0;
            r_WLo   <= '0;
            r_M     <= '0;
            r_NegQ  <= 1'b0;
        end else begin
            r_Done <= (r_State == FINISH) | w_DivReject;
            case (r_State)
                IDLE: begin
                    if (w_Launch) begin
                        r_WHi   <= '0;
                        r_WLo   <= w_MagA;
                        r_M     <= w_MagB;
                        r_Count <= 5'd31;
                        r_NegQ  <= w_SignA ^ w_SignB;
                    end else if (!i_Start) begin
                        // A start in the same cycle (even a rejected one)
                        // drops the HI/LO write.
                        if (i_HIWrite) r_HI <= i_WData;
                        if (i_LOWrite) r_LO <= i_WData;
                    end
                end
                RUN: begin
                    r_WHi <= w_StepHi;
                    r_WLo <= w_StepLo;
                    if (r_Count != 5'd0) r_Count <= r_Count - 5'd1;
                end
                FINISH: begin
                    r_HI <= w_FinHi;
                    r_LO <= w_FinLo;
                end
                default: ;
            endcase
        end
    end

    assign o_HI     = r_HI;
    assign o_LO     = r_LO;
    assign o_Busy   = (r_State != IDLE);
    assign o_Done   = r_Done;
    assign co_Stall = o_Busy & (i_Start | i_Access | i_HIWrite | i_LOWrite);

endmodule

// File: doc/qm_muldiv.md
QM_MULDIV -- requirements
Module: qm_muldiv

Interface
REQ-001 The block SHALL have these ports:
- i_Clock  in  1  system clock, rising edge
- i_Reset  in  1  asynchronous, active-high reset
- i_Start  in  1  request a new operation
- i_Op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- i_A  in  32  operand A (multiplicand / dividend), sampled on accepted start
- i_B  in  32  operand B (multiplier / divisor), sampled on accepted start
- i_Access  in  1  pipeline is reading HI/LO (MFHI/MFLO) this cycle
- i_HIWrite  in  1  MTHI write strobe
- i_LOWrite  in  1  MTLO write strobe
- i_WData  in  32  data for MTHI/MTLO
- o_HI  out  32  HI register
- o_LO  out  32  LO register
- o_Busy  out  1  operation in progress
- o_Done  out  1  one-cycle completion pulse
- co_Stall  out  1  stall request to the pipeline
REQ-002 The block SHALL use one clock, i_Clock; i_Reset SHALL be asynchronous and active-high.

Function
REQ-003 The FSM SHALL have states IDLE, RUN and FINISH; the reset state SHALL be IDLE.
REQ-004 In IDLE, i_Start=1 SHALL be accepted: operands and i_Op are latched, the 5-bit counter loads 31, and the FSM enters RUN.
REQ-005 In RUN, one radix-2 step (shift-add multiply / restoring divide) SHALL be performed on unsigned magnitudes per cycle; RUN SHALL exit to FINISH after the cycle with counter 0 (32 cycles).
REQ-006 FINISH SHALL last 1 cycle: apply sign correction, write HI/LO, and return to IDLE.
REQ-007 For an accepted start at edge E0, o_Busy SHALL be 1 in cycles E0+1..E0+33; o_Done=1 and the new HI/LO SHALL be visible in cycle E0+34 only.
REQ-008 Multiply SHALL produce the 64-bit product as {HI,LO}; MULT treats operands as two's complement, and the 64-bit magnitude product is negated when the operand signs differ.
REQ-009 Divide SHALL produce LO=quotient and HI=remainder; for DIV the quotient is negative when the signs differ, and the remainder takes the dividend's sign.
REQ-010 Divide by zero (DIV or DIVU) SHALL complete with normal latency, giving LO=0xFFFFFFFF and HI=latched i_A.
REQ-011 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-012 i_Start while o_Busy=1 SHALL be ignored; the operation in flight is unaffected.
REQ-013 co_Stall SHALL be the combinational output o_Busy & (i_Start | i_Access | i_HIWrite | i_LOWrite).
REQ-014 In IDLE with i_Start=0, i_HIWrite / i_LOWrite SHALL load i_WData into HI / LO at the next edge; both strobes together SHALL load both registers.
REQ-015 i_HIWrite / i_LOWrite while busy SHALL be ignored.
REQ-016 When i_Start and a write strobe are both asserted in IDLE, the start SHALL win and the write is dropped.
REQ-017 HI/LO SHALL hold their previous values throughout RUN; intermediate state SHALL be kept in separate working registers.

Reset
REQ-018 Assertion of i_Reset SHALL immediately force the FSM to IDLE, HI=LO=0, o_Busy=0, o_Done=0, counter=0, and working registers to 0.
REQ-019 A reset during RUN or FINISH SHALL abort the operation with no o_Done pulse and no HI/LO update.
REQ-020 The first start SHALL be accepted at the first rising edge after i_Reset deasserts.

Configuration
REQ-021 With macro QM_MULDIV_DIV_EN defined, divide ops SHALL behave per REQ-009..REQ-011.
REQ-022 Without QM_MULDIV_DIV_EN, the divider datapath SHALL be absent; a divide start SHALL not enter RUN, o_Busy stays 0, o_Done pulses in cycle E0+1, and HI/LO are unchanged.
REQ-023 Multiply behaviour SHALL be identical with and without QM_MULDIV_DIV_EN.

Verification
REQ-024 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> at E0+34: o_Done=1, HI=0xFFFFFFFE, LO=0x00000001; o_Busy=1 for exactly 33 cycles.
REQ-025 MULT A=0xFFFFFFFD (-3) B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-026 DIV A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=5 B=0 -> LO=0xFFFFFFFF, HI=5.
REQ-027 MTHI 0x1234 in IDLE -> HI=0x1234 next cycle; MULTU 2*3, then at E0+5 i_Start=1 and i_HIWrite=1 -> co_Stall=1, both ignored, and the final HI=0, LO=6.
REQ-028 MULTU started, i_Reset pulsed at E0+10 -> o_Busy=0 immediately, HI=LO=0, no o_Done for 40 cycles.
REQ-029 With QM_MULDIV_DIV_EN undefined, DIVU 9/3 -> o_Done at E0+1, o_Busy never 1, and HI/LO unchanged.
